// File: rtl/add_sub_arbiter_if.sv
// Request/response bundle between NREQ clients and the shared add_sub arbiter.
// ADD_SUB_ARB_OVF_EN adds the registered signed-overflow flag rsp_ovf.
interface add_sub_arbiter_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_op;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_result;
    logic              rsp_cb;
`ifdef ADD_SUB_ARB_OVF_EN
    logic              rsp_ovf;
`endif

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_cb
`ifdef ADD_SUB_ARB_OVF_EN
        , output rsp_ovf
`endif
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_cb
`ifdef ADD_SUB_ARB_OVF_EN
        , input rsp_ovf
`endif
    );
endinterface

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one ripple-carry add_sub between NREQ requesters,
// with a single registered response slot. ADD_SUB_ARB_OVF_EN enables rsp_ovf.
module add_sub #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ctrl_i,
    output logic [N-1:0] s_o,
    output logic         cb_o
);
    always_comb begin
        logic c;
        logic bx;
        s_o = '0;
        c   = ctrl_i;
        for (int i = 0; i < int'(N); i++) begin
            bx     = b_i[i] ^ ctrl_i;
            s_o[i] = a_i[i] ^ bx ^ c;
            c      = (a_i[i] & bx) | (c & (a_i[i] ^ bx));
        end
        cb_o = c;
    end
endmodule

module add_sub_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_sub_arbiter_if.slave     bus
);
    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   result_q, result_d;
    logic           cb_q, cb_d;

    logic           can_issue, found, xfer;
    logic [IDW-1:0] gnt_idx;
    logic [NREQ-1:0] gnt;
    logic           op_sel;
    logic [N-1:0]   a_sel, b_sel, sum;
    logic           sum_cb;

    // rst_n gates issue so req_ready reads zero for the whole reset interval.
    assign can_issue = rst_n & ((state_q == StEmpty) | (bus.rsp_ready & (state_q == StFull)));

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!found && bus.req_valid[(int'(ptr_q) + k) % int'(NREQ)]) begin
                found   = 1'b1;
                gnt_idx = IDW'((int'(ptr_q) + k) % int'(NREQ));
            end
        end
    end

    assign xfer = can_issue & found;

    always_comb begin
        gnt = '0;
        if (xfer) gnt[gnt_idx] = 1'b1;
    end

    assign bus.req_ready = gnt;

    assign op_sel = bus.req_op[gnt_idx];
    assign a_sel  = bus.req_a[int'(gnt_idx)*int'(N) +: N];
    assign b_sel  = bus.req_b[int'(gnt_idx)*int'(N) +: N];

    add_sub #(.N(N)) u_add_sub (
        .a_i    (a_sel),
        .b_i    (b_sel),
        .ctrl_i (op_sel),
        .s_o    (sum),
        .cb_o   (sum_cb)
    );

`ifdef ADD_SUB_ARB_OVF_EN
    logic ovf_q, ovf_d, ovf_calc;
    // Subtract overflows when signs differ; add when they match. Either way the
    // result sign must disagree with a's.
    assign ovf_calc = ((a_sel[N-1] ^ b_sel[N-1]) == op_sel) & (sum[N-1] != a_sel[N-1]);
    assign bus.rsp_ovf = ovf_q;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        result_d = result_q;
        cb_d     = cb_q;
`ifdef ADD_SUB_ARB_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StEmpty: if (xfer) state_d = StFull;
            StFull:  if (bus.rsp_ready && !xfer) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
        if (xfer) begin
            id_d     = gnt_idx;
            result_d = sum;
            cb_d     = sum_cb;
            ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef ADD_SUB_ARB_OVF_EN
            ovf_d    = ovf_calc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            ptr_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
            cb_q     <= 1'b0;
`ifdef ADD_SUB_ARB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            result_q <= result_d;
            cb_q     <= cb_d;
`ifdef ADD_SUB_ARB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.rsp_valid  = (state_q == StFull);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_cb     = cb_q;
endmodule

// File: tb/tb_add_sub_arbiter.sv
// Directed bench for add_sub_arbiter with N=4, NREQ=4, IDW=2.
module tb_add_sub_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    add_sub_arbiter_if #(.N(4), .NREQ(4), .IDW(2)) bus ();

    add_sub_arbiter #(.N(4), .NREQ(4), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic op, input logic [3:0] a, input logic [3:0] b);
        bus.req_valid[i]     = 1'b1;
        bus.req_op[i]        = op;
        bus.req_a[i*4 +: 4]  = a;
        bus.req_b[i*4 +: 4]  = b;
    endtask

    task automatic do_reset;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        tick();
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid);
        end
        total++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 4'd0 || bus.rsp_cb !== 1'b0) begin
            bad++; $display("FAIL reset_fields got id=%0d res=%b cb=%b exp 0/0000/0",
                            bus.rsp_id, bus.rsp_result, bus.rsp_cb);
        end
        total++;
        if (bus.req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_add;
        do_reset();
        set_req(0, 1'b0, 4'd5, 4'd3);
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++; $display("FAIL add_ready got=%b exp=0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_result !== 4'b1000
            || bus.rsp_cb !== 1'b0) begin
            bad++; $display("FAIL add_rsp got v=%b id=%0d res=%b cb=%b exp 1/0/1000/0",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_cb);
        end
        tick();
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL add_drain got=%b exp=0", bus.rsp_valid);
        end
    endtask

    task automatic test_sub;
        do_reset();
        set_req(2, 1'b1, 4'd5, 4'd3);
        #1;
        total++;
        if (bus.req_ready !== 4'b0100) begin
            bad++; $display("FAIL sub_ready got=%b exp=0100", bus.req_ready);
        end
        tick();
        total++;
        if (bus.rsp_id !== 2'd2 || bus.rsp_result !== 4'b0010 || bus.rsp_cb !== 1'b1) begin
            bad++; $display("FAIL sub_pos got id=%0d res=%b cb=%b exp 2/0010/1",
                            bus.rsp_id, bus.rsp_result, bus.rsp_cb);
        end
        set_req(2, 1'b1, 4'd3, 4'd5);
        #1;
        total++;
        if (bus.req_ready !== 4'b0100) begin
            bad++; $display("FAIL sub_ready2 got=%b exp=0100", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_result !== 4'b1110
            || bus.rsp_cb !== 1'b0) begin
            bad++; $display("FAIL sub_neg got v=%b id=%0d res=%b cb=%b exp 1/2/1110/0",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_cb);
        end
        tick();
`ifdef ADD_SUB_ARB_OVF_EN
        do_reset();
        set_req(0, 1'b0, 4'd7, 4'd1);
        tick();
        total++;
        if (bus.rsp_result !== 4'b1000 || bus.rsp_ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_add got res=%b ovf=%b exp 1000/1",
                            bus.rsp_result, bus.rsp_ovf);
        end
        set_req(1, 1'b1, 4'd5, 4'd3);
        bus.req_valid[0] = 1'b0;
        tick();
        total++;
        if (bus.rsp_result !== 4'b0010 || bus.rsp_ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_sub_ok got res=%b ovf=%b exp 0010/0",
                            bus.rsp_result, bus.rsp_ovf);
        end
        bus.req_valid[1] = 1'b0;
        set_req(2, 1'b1, 4'b1000, 4'd1);
        tick();
        bus.req_valid = '0;
        total++;
        if (bus.rsp_result !== 4'b0111 || bus.rsp_ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_sub got res=%b ovf=%b exp 0111/1",
                            bus.rsp_result, bus.rsp_ovf);
        end
        tick();
`endif
    endtask

    task automatic test_round_robin;
        int g;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i + 1), 4'd1);
        #1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            total++;
            if (bus.req_ready !== (4'b0001 << g)) begin
                bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready,
                                4'b0001 << g);
            end
            tick();
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(g) || bus.rsp_result !== 4'(g + 2)) begin
                bad++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d res=%0d exp 1/%0d/%0d", k,
                                bus.rsp_valid, bus.rsp_id, bus.rsp_result, g, g + 2);
            end
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(i + 1), 4'd1);
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0
                || bus.rsp_result !== 4'd2 || bus.rsp_cb !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b id=%0d res=%0d exp 0000/1/0/2",
                                k, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 4'b0010) begin
            bad++; $display("FAIL bp_release_ready got=%b exp=0010", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 4'd3) begin
            bad++; $display("FAIL bp_next got v=%b id=%0d res=%0d exp 1/1/3",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        tick();
    endtask

    task automatic test_fairness;
        logic [1:0] exp_id [3];
        exp_id[0] = 2'd1; exp_id[1] = 2'd3; exp_id[2] = 2'd1;
        do_reset();
        set_req(1, 1'b0, 4'd1, 4'd1);
        set_req(3, 1'b0, 4'd3, 4'd1);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.req_ready !== (4'b0001 << exp_id[k])) begin
                bad++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, bus.req_ready,
                                4'b0001 << exp_id[k]);
            end
            tick();
            total++;
            if (bus.rsp_id !== exp_id[k]) begin
                bad++; $display("FAIL fair_id[%0d] got=%0d exp=%0d", k, bus.rsp_id, exp_id[k]);
            end
        end
        bus.req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
                bad++; $display("FAIL fair_idle[%0d] got rdy=%b v=%b exp 0000/0", k,
                                bus.req_ready, bus.rsp_valid);
            end
        end
        bus.req_valid[1] = 1'b1;
        bus.req_valid[3] = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 4'b1000) begin
            bad++; $display("FAIL fair_ptr_held got=%b exp=1000", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_reset_midop;
        do_reset();
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b0, 4'd5, 4'd3);
        tick();
        bus.req_valid = '0;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 4'd0) begin
            bad++; $display("FAIL midrst_clear got v=%b res=%b exp 0/0000",
                            bus.rsp_valid, bus.rsp_result);
        end
        set_req(0, 1'b0, 4'd1, 4'd2);
        set_req(2, 1'b0, 4'd4, 4'd4);
        #2;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_grant got rdy=%b v=%b exp 0001/0",
                            bus.req_ready, bus.rsp_valid);
        end
        tick();
        bus.req_valid = '0;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_result !== 4'd3) begin
            bad++; $display("FAIL midrst_rsp got v=%b id=%0d res=%0d exp 1/0/3",
                            bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
- Shares one add_sub (N-bit ripple-carry adder-subtractor) between NREQ requesters.
- Round-robin arbitration with a valid/ready request handshake per requester.
- Single-entry registered response with backpressure; response carries the requester ID.
- Sits between client blocks and the shared add_sub datapath; instantiates add_sub #(.N(N)) internally.

Parameters:
N, 4, operand/result width
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant (one-hot or zero)
req_op  in  NREQ  per-requester op: 0 = add, 1 = subtract (add_sub ctrl)
req_a  in  NREQ*N  packed operand A, requester i at [i*N +: N]
req_b  in  NREQ*N  packed operand B, same packing
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  index of the requester that issued the response
rsp_result  out  N  add_sub result
rsp_cb  out  1  add_sub carry/borrow bit

Behaviour:
- Reset: asynchronous on rst_n low. rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cb=0, state=EMPTY, RR pointer=0 (requester 0 highest priority). req_ready is combinational and therefore 0 while in reset.
- Datapath: the shared add_sub computes result = a + (b ^ {N{op}}) + op, modulo 2^N. cb = carry-out of that sum.
  - Add: cb=1 on unsigned overflow.
  - Subtract: cb=1 means no borrow (a >= b unsigned).
- FSM, 2 states:
  - EMPTY: output register free.
  - FULL: rsp_valid=1, holding a response.
- can_issue = (state==EMPTY) | (rsp_ready & state==FULL).
- Grant:
  - If can_issue and any req_valid, assert req_ready for exactly one requester: the first valid index at or after the RR pointer, wrapping modulo NREQ.
  - A transfer occurs when req_valid[i] & req_ready[i] in the same cycle.
  - req_ready depends combinationally on req_valid, state and rsp_ready.
- Transfer: the granted requester's op/a/b are muxed into add_sub. On the next clock edge, result/cb/id are registered, rsp_valid=1, state=FULL, and the RR pointer becomes (granted index + 1) mod NREQ. Latency: request accept to rsp_valid = 1 cycle.
- FULL & rsp_ready & no transfer: rsp_valid falls to 0, state=EMPTY.
- FULL & rsp_ready & transfer: the register is overwritten with the new response and stays FULL. Back-to-back throughput is 1 op/cycle.
- FULL & !rsp_ready: no grants; output fields held stable until accepted.
- The RR pointer changes only on a transfer. With no requests it holds its value.
- A requester must hold valid/op/a/b stable until granted; the block does not latch unaccepted requests.
- Reset mid-operation: a pending response is discarded and no response is produced for it.
- NREQ not a power of 2: pointer wrap goes from NREQ-1 to 0. Unused ID codes never appear.

Optional Feature:
- Macro ADD_SUB_ARB_OVF_EN.
- Defined:
  - Extra output port rsp_ovf (1 bit), the signed two's-complement overflow of the registered operation.
  - Add: operand sign bits equal and the result sign differs.
  - Subtract: operand sign bits differ and the result sign differs from a's.
  - Reset value 0; registered and held with the other rsp_* fields.
- Undefined: the port is absent and no overflow logic is built.

Test Plan:
- Single add: req0 op=0 a=5 b=3 -> req_ready[0]=1 same cycle; next cycle rsp_valid=1, id=0, result=4'b1000, cb=0.
- Single subtract: req2 op=1 a=5 b=3 -> rsp id=2, result=4'b0010, cb=1. Then a=3 b=5 -> result=4'b1110, cb=0. With ADD_SUB_ARB_OVF_EN, 7+1 -> result=4'b1000, ovf=1.
- Round-robin: all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id follows one cycle later with no bubbles.
- Backpressure: rsp_ready=0 after the first response -> req_ready all 0, rsp_* held for 5 cycles. Raise rsp_ready -> the held response is accepted and the next grant occurs in the same cycle.
- Fairness: req1 valid continuously and req3 valid -> grants alternate 1,3,1,3; the RR pointer is unchanged across idle cycles.
- Reset mid-op: assert rst_n=0 asynchronously while FULL -> rsp_valid=0 immediately. After release, the first grant goes to requester 0 when 0 and 2 are both valid.
